// File: rtl/load_store_unit_if.sv
// ============================================================================
// Module   : load_store_unit_if
// Purpose  : Data-memory req/ack bus between the load/store unit and memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module   : load_store_unit
// Purpose  : Multi-cycle byte/half/word load/store stage over a req/ack bus.
// Revision : 1.0
// ============================================================================
`default_nettype none

module load_store_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        start,
    input  wire logic        is_store,
    input  wire logic [2:0]  funct3,
    input  wire logic [31:0] addr,
    input  wire logic [31:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [31:0]      rdata,
    output logic             misalign,
    output logic             bus_err,
    load_store_unit_if.master mem
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic             r_is_store;
    logic [2:0]       r_funct3;
    logic [1:0]       r_off;
    logic [CNT_W-1:0] r_cnt;
    logic             r_misalign;
    logic             r_bus_err;
    logic [31:0]      r_rdata;
    logic [31:0]      r_mem_addr;
    logic [3:0]       r_mem_wstrb;
    logic [31:0]      r_mem_wdata;

    logic             w_illegal;
    logic             w_misal;
    logic             w_timeout;
    logic [3:0]       w_strb;
    logic [31:0]      w_wdata;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load;

    // Decode of the request presented in IDLE
    always_comb begin
        if (is_store) begin
            w_illegal = funct3[2] | (funct3[1:0] == 2'b11);
        end else begin
            w_illegal = (funct3 == 3'b011) | (funct3[2:1] == 2'b11);
        end
        w_misal = ((funct3[1:0] == 2'b01) & addr[0]) |
                  ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
    end

    always_comb begin
        w_strb  = 4'b0000;
        w_wdata = wdata;
        case (funct3[1:0])
            2'b00: begin
                w_strb  = 4'b0001 << addr[1:0];
                w_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                w_strb  = 4'b0011 << addr[1:0];
                w_wdata = {2{wdata[15:0]}};
            end
            default: begin
                w_strb  = 4'b1111;
                w_wdata = wdata;
            end
        endcase
        if (!is_store) begin
            w_strb = 4'b0000;
        end
    end

    // Lane extraction of the returned word
    always_comb begin
        w_byte = mem.mem_rdata[7:0];
        case (r_off)
            2'd0:    w_byte = mem.mem_rdata[7:0];
            2'd1:    w_byte = mem.mem_rdata[15:8];
            2'd2:    w_byte = mem.mem_rdata[23:16];
            default: w_byte = mem.mem_rdata[31:24];
        endcase
        w_half = r_off[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = mem.mem_rdata;
        endcase
    end

    assign w_timeout = (r_cnt == c_cnt_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = (w_illegal | w_misal) ? S_FIN : S_REQ;
                end
            end
            S_REQ: begin
                if (mem.mem_ack | w_timeout) begin
                    w_next_state = S_FIN;
                end
            end
            S_FIN:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy          = (r_state == S_REQ);
        done          = (r_state == S_FIN);
        misalign      = done & r_misalign;
        bus_err       = done & r_bus_err;
        rdata         = r_rdata;
        mem.mem_req   = (r_state == S_REQ);
        mem.mem_we    = (r_state == S_REQ) & r_is_store;
        mem.mem_addr  = r_mem_addr;
        mem.mem_wstrb = r_mem_wstrb;
        mem.mem_wdata = r_mem_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_store  <= 1'b0;
            r_funct3    <= 3'd0;
            r_off       <= 2'd0;
            r_cnt       <= '0;
            r_misalign  <= 1'b0;
            r_bus_err   <= 1'b0;
            r_rdata     <= 32'd0;
            r_mem_addr  <= 32'd0;
            r_mem_wstrb <= 4'd0;
            r_mem_wdata <= 32'd0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_is_store <= is_store;
                r_funct3   <= funct3;
                r_off      <= addr[1:0];
                r_cnt      <= '0;
                r_bus_err  <= w_illegal;
                r_misalign <= ~w_illegal & w_misal;
                // Bus registers only change for accesses that really go out
                if (!w_illegal && !w_misal) begin
                    r_mem_addr  <= {addr[31:2], 2'b00};
                    r_mem_wstrb <= w_strb;
                    r_mem_wdata <= w_wdata;
                end
            end else if (r_state == S_REQ) begin
                if (mem.mem_ack) begin
                    if (!r_is_store) begin
                        r_rdata <= w_load;
                    end
                end else if (w_timeout) begin
                    r_bus_err <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Scoreboard bench for load_store_unit with a random memory responder.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_load_store_unit;

    localparam int TIMEOUT = 16;

    typedef struct {
        bit          mis;
        bit          err;
        logic [31:0] rd;
        int          reqc;
    } done_t;

    typedef struct {
        logic [31:0] a;
        bit          we;
        logic [3:0]  strb;
        logic [31:0] wd;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        busy, done, misalign, bus_err;
    logic [31:0] rdata;

    load_store_unit_if mem_if ();

    load_store_unit #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .is_store (is_store),
        .funct3   (funct3),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .rdata    (rdata),
        .misalign (misalign),
        .bus_err  (bus_err),
        .mem      (mem_if)
    );

    always #5 clk = ~clk;

    done_t       done_q[$];
    bus_t        bus_q[$];
    int          checks = 0;
    int          failures = 0;
    int          ack_wait = 0;
    logic [31:0] ack_data = 32'd0;
    logic [31:0] last_load = 32'd0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ext(bit [2:0] f3, int off, logic [31:0] w);
        logic [31:0] bv, hv;
        bv = (w >> (8 * off)) % 256;
        hv = (off >= 2) ? (w / 65536) : (w % 65536);
        case (f3)
            3'd0:    return (bv >= 128) ? bv - 32'd256 : bv;
            3'd1:    return (hv >= 32768) ? hv - 32'd65536 : hv;
            3'd4:    return bv;
            3'd5:    return hv;
            default: return w;
        endcase
    endfunction

    // Memory responder: acks after ack_wait idle request cycles
    initial begin
        int rc = 0;
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (mem_if.mem_req) begin
                mem_if.mem_ack   = (rc == ack_wait);
                mem_if.mem_rdata = (rc == ack_wait) ? ack_data : $urandom;
                rc++;
            end else begin
                mem_if.mem_ack   = 1'b0;
                mem_if.mem_rdata = $urandom;
                rc = 0;
            end
        end
    end

    // Monitor: checks bus cycles and completions against the queues
    initial begin
        int    reqc = 0;
        bus_t  cur;
        done_t e;
        cur = '{a: 32'd0, we: 1'b0, strb: 4'd0, wd: 32'd0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                reqc = 0;
                continue;
            end
            check("busy_vs_req", {31'd0, busy}, {31'd0, mem_if.mem_req});
            if (mem_if.mem_req) begin
                if (reqc == 0) begin
                    if (bus_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_req actual=1 expected=0");
                    end else begin
                        cur = bus_q.pop_front();
                    end
                end
                check("mem_addr", mem_if.mem_addr, cur.a);
                check("mem_we", {31'd0, mem_if.mem_we}, {31'd0, cur.we});
                check("mem_wstrb", {28'd0, mem_if.mem_wstrb}, {28'd0, cur.strb});
                if (cur.we) check("mem_wdata", mem_if.mem_wdata, cur.wd);
                reqc++;
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_done actual=1 expected=0");
                end else begin
                    e = done_q.pop_front();
                    check("misalign", {31'd0, misalign}, {31'd0, e.mis});
                    check("bus_err", {31'd0, bus_err}, {31'd0, e.err});
                    check("rdata", rdata, e.rd);
                    check("req_cycles", reqc, e.reqc);
                end
                reqc = 0;
            end else begin
                check("flags_outside_fin", {30'd0, misalign, bus_err}, 32'd0);
            end
        end
    end

    task automatic issue(bit st, bit [2:0] f3, bit [31:0] a, bit [31:0] wd,
                         int aw, bit [31:0] rd, bit poke);
        int    size, off, n;
        bit    legal, mis;
        done_t e;
        bus_t  b;
        size  = 1 << f3[1:0];
        off   = a % 4;
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        mis   = legal && ((off % size) != 0);
        e.mis  = mis;
        e.err  = !legal || (!mis && aw >= TIMEOUT);
        e.reqc = (legal && !mis) ? ((aw + 1 < TIMEOUT) ? aw + 1 : TIMEOUT) : 0;
        if (legal && !mis && !st && aw < TIMEOUT) last_load = ext(f3, off, rd);
        e.rd = last_load;
        if (legal && !mis) begin
            b.a  = a - off;
            b.we = st;
            b.wd = 32'd0;
            for (int i = 0; i < 4; i++) begin
                b.strb[i] = st && (i >= off) && (i < off + size);
                b.wd = b.wd | (((wd >> (8 * (i % size))) % 256) << (8 * i));
            end
            bus_q.push_back(b);
        end
        done_q.push_back(e);
        ack_wait = aw;
        ack_data = rd;
        @(negedge clk);
        start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
        @(negedge clk);
        start = 1'b0; is_store = $urandom; funct3 = $urandom; addr = $urandom; wdata = $urandom;
        n = 0;
        while (!done && n < 100) begin
            start = poke && busy;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (!done) begin
            checks++; failures++;
            $display("FAIL done_timeout actual=0 expected=1");
        end else if (poke) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic reset_checks(string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_flags"}, {30'd0, misalign, bus_err}, 32'd0);
        check({tag, "_rdata"}, rdata, 32'd0);
        check({tag, "_req_we"}, {30'd0, mem_if.mem_req, mem_if.mem_we}, 32'd0);
        check({tag, "_mem_addr"}, mem_if.mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, mem_if.mem_wdata, 32'd0);
        check({tag, "_mem_wstrb"}, {28'd0, mem_if.mem_wstrb}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_t b;
        repeat (3) @(negedge clk);
        reset_checks("reset");
        rst_n = 1'b1;
        @(negedge clk);

        issue(1'b0, 3'b010, 32'h100, 32'h0, 2, 32'hDEADBEEF, 1'b0);
        issue(1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF7F01, 1'b0);
        issue(1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80FF7F01, 1'b0);
        issue(1'b1, 3'b001, 32'h202, 32'h0000ABCD, 1, 32'h0, 1'b0);
        issue(1'b0, 3'b010, 32'h101, 32'h0, 0, 32'h12345678, 1'b0);
        issue(1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 255, 32'h0, 1'b0);
        issue(1'b0, 3'b001, 32'h402, 32'h0, TIMEOUT - 1, 32'h8001_7FFF, 1'b1);
        issue(1'b0, 3'b101, 32'h400, 32'h0, TIMEOUT, 32'h1111_2222, 1'b0);
        issue(1'b0, 3'b011, 32'h500, 32'h0, 0, 32'h0, 1'b0);
        issue(1'b1, 3'b100, 32'h500, 32'h0, 0, 32'h0, 1'b0);
        issue(1'b1, 3'b000, 32'h601, 32'h0000_00A5, 0, 32'h0, 1'b1);

        // Reset pulled in the middle of a stalled load
        b = '{a: 32'h700, we: 1'b0, strb: 4'd0, wd: 32'd0};
        bus_q.push_back(b);
        ack_wait = 255;
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h700;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_req", {31'd0, mem_if.mem_req}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        last_load = 32'd0;
        @(negedge clk);
        reset_checks("midreset");
        rst_n = 1'b1;
        issue(1'b0, 3'b010, 32'h800, 32'h0, 0, 32'h0BAD_F00D, 1'b0);

        for (int i = 0; i < 150; i++) begin
            int aw;
            aw = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 2)
                                            : $urandom_range(0, 4);
            issue(1'(($urandom_range(0, 2) == 0)), 3'($urandom), $urandom, $urandom,
                  aw, $urandom, 1'($urandom));
        end

        repeat (5) @(negedge clk);
        check("done_q_empty", done_q.size(), 32'd0);
        check("bus_q_empty", bus_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
